// File: rtl/bus_sequencer.sv
// Bus initiator for the shared register-file bus: accepts one instruction per
// handshake and sequences address and enables for NOP, MOV, LDI and HALT.
module bus_sequencer #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] instruction,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic                  bus_out_en,
    output logic [ADDR_WIDTH-1:0] register_addr,
    output logic                  bus_register_input_en,
    output logic                  bus_register_output_en,
    output logic                  busy,
    output logic                  halted,
    output logic                  illegal_op
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_LDI  = 4'h2;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_SRC  = 2'd1,
        WRITE_DST = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t                  state;
    logic [2*ADDR_WIDTH-1:0] ir;   // {dst, src}; the opcode is consumed at accept
    logic [DATA_WIDTH-1:0]   tmp;

    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] imm;
    logic                  accept;

    assign opcode = instruction[DATA_WIDTH-1 -: 4];
    assign imm    = instruction[ADDR_WIDTH-1:0];
    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ir         <= '0;
            tmp        <= '0;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ir <= instruction[2*ADDR_WIDTH-1:0];
                        case (opcode)
                            OP_NOP:  state <= IDLE;
                            OP_MOV:  state <= READ_SRC;
                            OP_LDI: begin
                                tmp   <= {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, imm};
                                state <= WRITE_DST;
                            end
                            OP_HALT: state <= HALTED;
                            default: illegal_op <= 1'b1;
                        endcase
                    end
                end
                READ_SRC: begin
                    tmp   <= bus_in;
                    state <= WRITE_DST;
                end
                WRITE_DST: state <= IDLE;
                HALTED:    state <= HALTED;
                default:   state <= IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so inputs never reach the enables combinationally.
    always_comb begin
        instr_ready            = 1'b0;
        bus_out                = '0;
        bus_out_en             = 1'b0;
        register_addr          = '0;
        bus_register_input_en  = 1'b0;
        bus_register_output_en = 1'b0;
        busy                   = 1'b0;
        halted                 = 1'b0;
        case (state)
            IDLE: instr_ready = reset;
            READ_SRC: begin
                register_addr          = ir[ADDR_WIDTH-1:0];
                bus_register_output_en = 1'b1;
                busy                   = 1'b1;
            end
            WRITE_DST: begin
                register_addr         = ir[2*ADDR_WIDTH-1:ADDR_WIDTH];
                bus_out               = tmp;
                bus_out_en            = 1'b1;
                bus_register_input_en = 1'b1;
                busy                  = 1'b1;
            end
            HALTED: halted = 1'b1;
            default: instr_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: stimulus pushes expected bus writes and
// illegal-op pulses, a monitor pops and compares them as the DUT presents them.
module tb_bus_sequencer;

    logic        clock;
    logic        reset;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] bus_in;
    logic [15:0] bus_out;
    logic        bus_out_en;
    logic [5:0]  register_addr;
    logic        bus_register_input_en;
    logic        bus_register_output_en;
    logic        busy;
    logic        halted;
    logic        illegal_op;

    bus_sequencer #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .instruction            (instruction),
        .instr_valid            (instr_valid),
        .instr_ready            (instr_ready),
        .bus_in                 (bus_in),
        .bus_out                (bus_out),
        .bus_out_en             (bus_out_en),
        .register_addr          (register_addr),
        .bus_register_input_en  (bus_register_input_en),
        .bus_register_output_en (bus_register_output_en),
        .busy                   (busy),
        .halted                 (halted),
        .illegal_op             (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register file read model driving the shared bus
    logic [15:0] regs [64];
    assign bus_in = bus_register_output_en ? regs[register_addr] : 16'h0000;

    typedef struct {
        bit          ill;
        logic [5:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push_wr(input logic [5:0] a, input logic [15:0] d);
        exp_t e;
        e.ill = 1'b0; e.addr = a; e.data = d;
        q.push_back(e);
    endtask

    task automatic push_ill();
        exp_t e;
        e.ill = 1'b1; e.addr = '0; e.data = '0;
        q.push_back(e);
    endtask

    // Present an instruction and return the cycle number of the accepting edge
    task automatic issue(input logic [15:0] ins, output int acc);
        int n = 0;
        instruction = ins;
        instr_valid = 1'b1;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL issue_timeout: got ready=%0b expected 1 within 20 cycles", instr_ready);
        end
        @(posedge clock); #1;
        acc = cyc;
        instr_valid = 1'b0;
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [5:0] d, input logic [5:0] s);
        return {op, d, s};
    endfunction

    // Monitor
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            checks++;
            if (bus_register_input_en && bus_register_output_en) begin
                errors++;
                $display("FAIL en_exclusive: got in=1 out=1 expected not both");
            end
            checks++;
            if (bus_out_en !== bus_register_input_en) begin
                errors++;
                $display("FAIL out_en_tracks_in_en: got %0b expected %0b", bus_out_en, bus_register_input_en);
            end
            checks++;
            if (!bus_out_en && bus_out !== 16'h0) begin
                errors++;
                $display("FAIL bus_out_idle_zero: got %h expected 0000", bus_out);
            end
            if (bus_register_input_en) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h expected none", register_addr, bus_out);
                end else begin
                    e = q.pop_front();
                    if (e.ill || register_addr !== e.addr || bus_out !== e.data) begin
                        errors++;
                        $display("FAIL write: got addr=%0d data=%h expected ill=%0b addr=%0d data=%h",
                                 register_addr, bus_out, e.ill, e.addr, e.data);
                    end
                end
            end
            if (illegal_op) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_illegal: got illegal_op=1 expected none");
                end else begin
                    e = q.pop_front();
                    if (!e.ill) begin
                        errors++;
                        $display("FAIL illegal: got illegal_op expected write addr=%0d data=%h", e.addr, e.data);
                    end
                end
            end
        end
    end

    initial begin
        int a0, a1, a2, a3;
        for (int i = 0; i < 64; i++) regs[i] = 16'h0000;
        regs[7]  = 16'hBEEF;
        regs[4]  = 16'h1234;
        regs[20] = 16'h0F0F;
        reset = 1'b0;
        instr_valid = 1'b0;
        instruction = 16'h0000;

        repeat (3) @(posedge clock);
        #1;
        chk("rst_bus_out_en", bus_out_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_addr", register_addr, 0);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        chk("rst_ready_after", instr_ready, 1);

        // LDI dst=5 imm=0x2A: write one cycle after accept
        push_wr(6'd5, 16'h002A);
        issue(mk(4'h2, 6'd5, 6'h2A), a0);
        chk("ldi_in_en", bus_register_input_en, 1);
        chk("ldi_addr", register_addr, 5);
        chk("ldi_ready_low", instr_ready, 0);
        @(posedge clock); #1;
        chk("ldi_back_idle", instr_ready, 1);
        chk("ldi_busy_clear", busy, 0);

        // MOV dst=3 src=7 reads 0xBEEF then writes it
        push_wr(6'd3, 16'hBEEF);
        issue(mk(4'h1, 6'd3, 6'd7), a0);
        chk("mov_rd_addr", register_addr, 7);
        chk("mov_rd_out_en", bus_register_output_en, 1);
        chk("mov_rd_in_en", bus_register_input_en, 0);
        chk("mov_rd_busy", busy, 1);
        @(posedge clock); #1;
        chk("mov_wr_in_en", bus_register_input_en, 1);
        chk("mov_wr_addr", register_addr, 3);
        @(posedge clock); #1;

        // MOV src == dst rewrites the same value
        push_wr(6'd4, 16'h1234);
        issue(mk(4'h1, 6'd4, 6'd4), a0);
        repeat (2) @(posedge clock);
        #1;

        // Four back-to-back LDIs, one accepted every second cycle
        push_wr(6'd10, 16'h0001);
        issue(mk(4'h2, 6'd10, 6'h01), a0);
        chk("b2b_ready_low", instr_ready, 0);
        push_wr(6'd11, 16'h0002);
        issue(mk(4'h2, 6'd11, 6'h02), a1);
        push_wr(6'd12, 16'h0003);
        issue(mk(4'h2, 6'd12, 6'h03), a2);
        push_wr(6'd13, 16'h003F);
        issue(mk(4'h2, 6'd13, 6'h3F), a3);
        chk("ldi_gap1", a1 - a0, 2);
        chk("ldi_gap2", a2 - a1, 2);
        chk("ldi_gap3", a3 - a2, 2);
        @(posedge clock); #1;

        // Back-to-back MOVs, one every third cycle
        push_wr(6'd1, 16'h0F0F);
        issue(mk(4'h1, 6'd1, 6'd20), a0);
        push_wr(6'd2, 16'hBEEF);
        issue(mk(4'h1, 6'd2, 6'd7), a1);
        chk("mov_gap", a1 - a0, 3);
        repeat (2) @(posedge clock);
        #1;

        // Undefined opcode 0x7
        push_ill();
        issue(mk(4'h7, 6'd9, 6'd9), a0);
        chk("ill_pulse", illegal_op, 1);
        chk("ill_no_in_en", bus_register_input_en, 0);
        chk("ill_no_out_en", bus_register_output_en, 0);
        @(posedge clock); #1;
        chk("ill_pulse_end", illegal_op, 0);
        chk("ill_ready", instr_ready, 1);

        // NOP stays idle
        issue(mk(4'h0, 6'd1, 6'd2), a0);
        chk("nop_busy", busy, 0);
        chk("nop_ready", instr_ready, 1);

        // HALT blocks a following MOV until reset
        issue(mk(4'hF, 6'd0, 6'd0), a0);
        chk("halt_flag", halted, 1);
        chk("halt_ready", instr_ready, 0);
        instruction = mk(4'h1, 6'd3, 6'd7);
        instr_valid = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        chk("halt_hold", halted, 1);
        chk("halt_no_busy", busy, 0);
        instr_valid = 1'b0;
        @(negedge clock) reset = 1'b0;
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        chk("halt_cleared", halted, 0);
        chk("halt_ready_back", instr_ready, 1);

        // Reset during READ_SRC aborts the MOV without a write
        issue(mk(4'h1, 6'd9, 6'd7), a0);
        chk("abort_rd_phase", bus_register_output_en, 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_out_en", bus_register_output_en, 0);
        chk("abort_in_en", bus_register_input_en, 0);
        chk("abort_addr", register_addr, 0);
        chk("abort_busy", busy, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        push_wr(6'd6, 16'h0015);
        issue(mk(4'h2, 6'd6, 6'h15), a0);
        repeat (3) @(posedge clock);
        #1;

        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
